// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI slave.
// No logic; no latency; no backpressure.
// Holds the FSM state encoding, the AES block width and the default counter width.
package aes_spi_pkg;
    localparam int AES_BLOCK_W   = 128;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT_D = 3'd1,
        SHIFT_K = 3'd2,
        HOLD    = 3'd3,
        ERR     = 3'd4
    } spi_state_t;
endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in shift register with parallel load and combinational MSB tap.
// Latency: one clk per shifted bit; the MSB tap is combinational.
// No backpressure: shifts whenever shift_en is high, and load_en wins over shift_en.
module spi_shift_reg #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             msb
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_dat;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

    assign msb = q[WIDTH-1];
endmodule

// File: rtl/aes_spi_slave.sv
// SPI slave that receives AES data blocks on cs1 and keys on cs2; optional readback via AES_SPI_READBACK_EN.
// Latency: frame registers update, and valid pulses, one clk after the last bit is sampled.
// No backpressure: the master owns the clock and the selects; a frame aborts when its select is released early.
module aes_spi_slave
    import aes_spi_pkg::*;
#(
    parameter int WIDTH = AES_BLOCK_W,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs1,
    input  logic             cs2,
    input  logic             mosi,
`ifdef AES_SPI_READBACK_EN
    input  logic [WIDTH-1:0] result_in,
    input  logic             result_load,
`endif
    output logic             misod,
    output logic             misok,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] key_out,
    output logic             data_valid,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    spi_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             go_d, go_k, err_set, last_bit;
    logic             chan_k, pend_d, pend_k;
    logic             ld_en;
    logic [WIDTH-1:0] ld_dat, dsr, ksr;

`ifdef AES_SPI_READBACK_EN
    // Only a quiet IDLE may load, so the load can never collide with a shift.
    assign ld_en  = result_load && (state == IDLE) && cs1 && cs2;
    assign ld_dat = result_in;
`else
    assign ld_en  = 1'b0;
    assign ld_dat = '0;
`endif

    assign last_bit = (cnt == LAST);
    assign busy     = (state == SHIFT_D) || (state == SHIFT_K);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        go_d      = 1'b0;
        go_k      = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!cs1 && !cs2) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                end else begin
                    go_d = !cs1;
                    go_k = !cs2;
                end
            end
            SHIFT_D, SHIFT_K: begin
                if (!cs1 && !cs2) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                    cnt_nxt   = '0;
                end else if ((state == SHIFT_D) ? cs1 : cs2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    go_d = (state == SHIFT_D);
                    go_k = (state == SHIFT_K);
                end
            end
            HOLD: begin
                if (!cs1 && !cs2) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                end else if (chan_k ? cs2 : cs1) begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                if (cs1 && cs2) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // The edge that leaves IDLE already samples the first bit.
        if (go_d || go_k) begin
            if (last_bit) begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end else begin
                state_nxt = go_d ? SHIFT_D : SHIFT_K;
                cnt_nxt   = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            chan_k     <= 1'b0;
            pend_d     <= 1'b0;
            pend_k     <= 1'b0;
            data_out   <= '0;
            key_out    <= '0;
            data_valid <= 1'b0;
            key_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            if (go_d || go_k) chan_k <= go_k;
            pend_d     <= go_d && last_bit;
            pend_k     <= go_k && last_bit;
            data_valid <= pend_d;
            key_valid  <= pend_k;
            err        <= err_set;
            if (pend_d) data_out <= dsr;
            if (pend_k) key_out  <= ksr;
        end
    end

    spi_shift_reg #(.WIDTH(WIDTH)) u_data_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (go_d),
        .load_en  (ld_en),
        .load_dat (ld_dat),
        .sin      (mosi),
        .q        (dsr),
        .msb      (misod)
    );

    spi_shift_reg #(.WIDTH(WIDTH)) u_key_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (go_k),
        .load_en  (1'b0),
        .load_dat ('0),
        .sin      (mosi),
        .q        (ksr),
        .msb      (misok)
    );
endmodule

// File: tb/tb_aes_spi_slave.sv
// Bench for aes_spi_slave: master drives on negedge, observes on negedge, checks against a frame-level model.
module tb_aes_spi_slave;
    localparam int W = 128;

    logic clk = 1'b0, rst = 1'b0, cs1 = 1'b1, cs2 = 1'b1, mosi = 1'b0;
    logic misod, misok, data_valid, key_valid, busy, err;
    logic [W-1:0] data_out, key_out;
`ifdef AES_SPI_READBACK_EN
    logic [W-1:0] result_in = '0;
    logic         result_load = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Model: what each shift register and output register should hold.
    logic [W-1:0] m_dsr = '0, m_ksr = '0, m_dout = '0, m_kout = '0;
    // Observations gathered by run_frame.
    logic [W-1:0] ob_miso, ob_prev;
    int           ob_early;
    logic         ob_busy_n, ob_busy_n1, ob_v1, ob_v2;

    always #5 clk = ~clk;

    aes_spi_slave dut (
        .clk        (clk),
        .rst        (rst),
        .cs1        (cs1),
        .cs2        (cs2),
        .mosi       (mosi),
`ifdef AES_SPI_READBACK_EN
        .result_in  (result_in),
        .result_load(result_load),
`endif
        .misod      (misod),
        .misok      (misok),
        .data_out   (data_out),
        .key_out    (key_out),
        .data_valid (data_valid),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err)
    );

    function automatic logic [W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Sends nbits of val MSB first on one channel, then releases both selects.
    task automatic run_frame(input bit k, input logic [W-1:0] val, input int nbits);
        ob_miso  = '0;
        ob_early = 0;
        ob_prev  = k ? m_ksr : m_dsr;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ob_miso = {ob_miso[W-2:0], (k ? misok : misod)};
            if (data_valid || key_valid) ob_early++;
            cs1  = k;
            cs2  = !k;
            mosi = val[W-1-i];
        end
        @(negedge clk);
        if (data_valid || key_valid) ob_early++;
        ob_busy_n = busy;
        cs1 = 1'b1; cs2 = 1'b1; mosi = 1'b0;
        @(negedge clk);
        ob_busy_n1 = busy;
        ob_v1 = k ? key_valid : data_valid;
        @(negedge clk);
        ob_v2 = k ? key_valid : data_valid;
        if (nbits == W) begin
            if (k) begin m_ksr = val; m_kout = val; end
            else   begin m_dsr = val; m_dout = val; end
        end else if (k) m_ksr = (m_ksr << nbits) | (val >> (W - nbits));
        else            m_dsr = (m_dsr << nbits) | (val >> (W - nbits));
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++; if ({data_out, key_out} !== '0) begin tests_failed++; $display("FAIL reset_regs got %h %h want 0", data_out, key_out); end
        tests_run++; if ({data_valid, key_valid, busy, err, misod, misok} !== 6'b0) begin tests_failed++; $display("FAIL reset_flags got %b want 000000", {data_valid, key_valid, busy, err, misod, misok}); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if ({busy, err, data_valid} !== 3'b0) begin tests_failed++; $display("FAIL post_reset_idle got %b want 000", {busy, err, data_valid}); end
    endtask

    task automatic test_data_frame();
        run_frame(1'b0, 128'h00112233445566778899aabbccddeeff, W);
        tests_run++; if (ob_miso !== ob_prev) begin tests_failed++; $display("FAIL data_misod got %h want %h", ob_miso, ob_prev); end
        tests_run++; if (ob_early !== 0) begin tests_failed++; $display("FAIL data_early_valid got %0d want 0", ob_early); end
        tests_run++; if (ob_busy_n !== 1'b0) begin tests_failed++; $display("FAIL data_hold_busy got %b want 0", ob_busy_n); end
        tests_run++; if ({ob_v1, ob_v2} !== 2'b10) begin tests_failed++; $display("FAIL data_valid_pulse got %b want 10", {ob_v1, ob_v2}); end
        tests_run++; if (data_out !== m_dout) begin tests_failed++; $display("FAIL data_out got %h want %h", data_out, m_dout); end
    endtask

    task automatic test_key_frame();
        run_frame(1'b1, 128'h000102030405060708090a0b0c0d0e0f, W);
        tests_run++; if (key_out !== m_kout) begin tests_failed++; $display("FAIL key_out got %h want %h", key_out, m_kout); end
        tests_run++; if ({ob_v1, ob_v2} !== 2'b10) begin tests_failed++; $display("FAIL key_valid_pulse got %b want 10", {ob_v1, ob_v2}); end
        tests_run++; if (data_out !== m_dout) begin tests_failed++; $display("FAIL key_data_kept got %h want %h", data_out, m_dout); end
        run_frame(1'b1, '0, W);
        tests_run++; if (ob_miso !== ob_prev) begin tests_failed++; $display("FAIL key_misok got %h want %h", ob_miso, ob_prev); end
        tests_run++; if (key_out !== m_kout) begin tests_failed++; $display("FAIL key_zero got %h want %h", key_out, m_kout); end
    endtask

    task automatic test_abort();
        run_frame(1'b0, rand128(), 64);
        tests_run++; if ({ob_v1, ob_v2, ob_early != 0} !== 3'b0) begin tests_failed++; $display("FAIL abort_valid got %b want 000", {ob_v1, ob_v2, ob_early != 0}); end
        tests_run++; if ({ob_busy_n, ob_busy_n1} !== 2'b10) begin tests_failed++; $display("FAIL abort_busy got %b want 10", {ob_busy_n, ob_busy_n1}); end
        tests_run++; if (data_out !== m_dout) begin tests_failed++; $display("FAIL abort_data_kept got %h want %h", data_out, m_dout); end
        run_frame(1'b0, rand128(), W);
        tests_run++; if (ob_miso !== ob_prev) begin tests_failed++; $display("FAIL abort_partial got %h want %h", ob_miso, ob_prev); end
        tests_run++; if ({data_out, ob_v1} !== {m_dout, 1'b1}) begin tests_failed++; $display("FAIL abort_next got %h/%b want %h/1", data_out, ob_v1, m_dout); end
    endtask

    task automatic test_err();
        @(negedge clk);
        cs1 = 1'b0; cs2 = 1'b0;
        @(negedge clk);
        tests_run++; if ({err, busy} !== 2'b10) begin tests_failed++; $display("FAIL err_pulse got %b want 10", {err, busy}); end
        cs2 = 1'b1;
        @(negedge clk);
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL err_one_cycle got %b want 0", err); end
        for (int i = 0; i < 4; i++) begin
            mosi = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL err_stuck cycle %0d busy got %b want 0", i, busy); end
        end
        cs1 = 1'b1;
        run_frame(1'b0, rand128(), W);
        tests_run++; if (ob_miso !== ob_prev) begin tests_failed++; $display("FAIL err_no_shift got %h want %h", ob_miso, ob_prev); end
        tests_run++; if (data_out !== m_dout) begin tests_failed++; $display("FAIL err_next_frame got %h want %h", data_out, m_dout); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d, k, ds, ks, pd, pk;
        d = rand128(); k = rand128(); ds = '0; ks = '0;
        pd = m_dsr; pk = m_ksr;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            ds = {ds[W-2:0], misod};
            cs1 = 1'b0; mosi = d[W-1-i];
        end
        @(negedge clk);
        cs1 = 1'b1; cs2 = 1'b0; mosi = k[W-1];
        @(negedge clk);
        tests_run++; if ({data_valid, busy} !== 2'b10) begin tests_failed++; $display("FAIL b2b_idle got %b want 10", {data_valid, busy}); end
        tests_run++; if (data_out !== d) begin tests_failed++; $display("FAIL b2b_data got %h want %h", data_out, d); end
        tests_run++; if (ds !== pd) begin tests_failed++; $display("FAIL b2b_misod got %h want %h", ds, pd); end
        ks = {ks[W-2:0], misok};
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            ks = {ks[W-2:0], misok};
            mosi = k[W-1-i];
        end
        @(negedge clk);
        cs2 = 1'b1;
        @(negedge clk);
        tests_run++; if ({key_valid, key_out} !== {1'b1, k}) begin tests_failed++; $display("FAIL b2b_key got %b/%h want 1/%h", key_valid, key_out, k); end
        tests_run++; if (ks !== pk) begin tests_failed++; $display("FAIL b2b_misok got %h want %h", ks, pk); end
        m_dsr = d; m_dout = d; m_ksr = k; m_kout = k;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v;
        v = rand128();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cs1 = 1'b0; mosi = v[W-1-i];
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_dsr = '0; m_ksr = '0; m_dout = '0; m_kout = '0;
        tests_run++; if ({data_out, key_out} !== {m_dout, m_kout}) begin tests_failed++; $display("FAIL rstmid_regs got %h %h want 0", data_out, key_out); end
        tests_run++; if ({data_valid, key_valid, busy, err, misod, misok} !== 6'b0) begin tests_failed++; $display("FAIL rstmid_flags got %b want 000000", {data_valid, key_valid, busy, err, misod, misok}); end
        @(negedge clk);
        rst = 1'b1; cs1 = 1'b1;
        run_frame(1'b0, rand128(), W);
        tests_run++; if (ob_miso !== ob_prev) begin tests_failed++; $display("FAIL rstmid_misod got %h want %h", ob_miso, ob_prev); end
        tests_run++; if ({data_out, ob_v1, ob_early != 0} !== {m_dout, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL rstmid_next got %h/%b want %h/1", data_out, ob_v1, m_dout); end
    endtask

`ifdef AES_SPI_READBACK_EN
    task automatic test_readback();
        @(negedge clk);
        result_in = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        result_load = 1'b1;
        @(negedge clk);
        result_load = 1'b0;
        m_dsr = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        run_frame(1'b0, rand128(), W);
        tests_run++; if (ob_miso !== ob_prev) begin tests_failed++; $display("FAIL readback_misod got %h want %h", ob_miso, ob_prev); end
        tests_run++; if (data_out !== m_dout) begin tests_failed++; $display("FAIL readback_data got %h want %h", data_out, m_dout); end
    endtask
`endif

    initial begin
        test_reset();
        test_data_frame();
        test_key_frame();
        test_abort();
        test_err();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_SPI_READBACK_EN
        test_readback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
